vector_checker: RTL

VECTOR_CHECKER -- requirements
Module: vector_checker

---
 rtl/vector_checker.sv | 126 ++++++++++++
 1 files changed

// File: rtl/vector_checker.sv
// vector_checker: stored-vector stimulus/response checker. It applies a registered stimulus,
// compares the masked response one cycle later, and keeps mismatch statistics.
`default_nettype none

module vector_checker #(
  parameter int IN_W  = 1,
  parameter int OUT_W = 1,
  parameter int DEPTH = 16,
  parameter int ERR_W = 32,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int VW   = 1 + IN_W + 2 * OUT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [VW-1:0]    load_data,
  input  logic             start,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [AW:0]      vectornum,
  output logic [ERR_W-1:0] errors,
  output logic             err_pulse,
  output logic [AW:0]      first_err
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_CHECK, S_DONE} state_t;

  localparam logic [AW:0]      NONE    = {(AW+1){1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [AW:0]      LAST    = (AW+1)'(DEPTH - 1);

  state_t              state;
  logic [DEPTH-1:0]    valid_q;
  logic [VW-2:0]       mem [DEPTH];
  logic [OUT_W-1:0]    exp_q;
  logic [OUT_W-1:0]    mask_q;
  logic                wr;
  logic [AW-1:0]       rd_addr;
  logic [VW-2:0]       rd_word;
  logic                mismatch;

  // Only valid bits are reset; payload contents are don't-care until written.
  assign wr = load_en && !busy && ({1'b0, load_addr} < (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= '0;
    else if (wr) valid_q[load_addr] <= load_data[VW-1];
  end

  always_ff @(posedge clk) begin
    if (wr) mem[load_addr] <= load_data[VW-2:0];
  end

  assign rd_addr  = vectornum[AW-1:0];
  assign rd_word  = mem[rd_addr];
  assign mismatch = |((dut_out ^ exp_q) & mask_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      dut_in    <= '0;
      exp_q     <= '0;
      mask_q    <= '0;
      vectornum <= '0;
      errors    <= '0;
      err_pulse <= 1'b0;
      first_err <= NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vectornum <= '0;
            errors    <= '0;
            first_err <= NONE;
            state     <= S_APPLY;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        S_APPLY: begin
          if (!valid_q[rd_addr]) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (errors == '0);
          end else begin
            dut_in <= rd_word[VW-2 -: IN_W];
            exp_q  <= rd_word[2*OUT_W-1 -: OUT_W];
            mask_q <= rd_word[OUT_W-1:0];
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            if (errors != ERR_MAX) errors <= errors + ERR_W'(1);
            err_pulse <= 1'b1;
            if (first_err == NONE) first_err <= vectornum;
          end
          vectornum <= vectornum + (AW+1)'(1);
          // The last entry ends the run rather than wrapping the address.
          if (vectornum == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (errors == '0) && !mismatch;
          end else begin
            state <= S_APPLY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
